// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg -- shared types and constants for the instruction fetch unit.
//
// Contents:
//   state_e          fetch FSM state encoding (ST_FAULT exists only when
//                    FETCH_MISALIGN_CHECK_EN is defined)
//   NOP_INSTR        instruction presented after reset (addi x0, x0, 0)
//   DEFAULT_RESET_PC default first fetch address
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DELIVER = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DELIVER = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- single-outstanding-request instruction fetch FSM.
//
// Issues a one-cycle request at pc, waits for the memory response (re-issuing
// after TIMEOUT silent WAIT cycles), then presents the instruction until the
// consumer takes it. On consume the pc follows either instr_pc+4 or the
// redirect target.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   TIMEOUT   WAIT cycles allowed before the request is re-issued (>= 1)
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   imem_req          one-cycle request strobe (high in FETCH)
//   imem_addr         request address (= pc)
//   imem_valid        response strobe, only honoured in WAIT
//   imem_rdata        response data
//   instr, instr_pc   captured instruction and its address
//   pc_plus4          instr_pc + 4 (link value)
//   instr_valid       instr is presented for decode (high in DELIVER)
//   stall             consumer not accepting instr this cycle
//   PCsrc             redirect select, sampled on the consume cycle only
//   target_addr       redirect target, sampled on the consume cycle only
//   misalign_fault    (FETCH_MISALIGN_CHECK_EN only) sticky misaligned-redirect
//                     fault, cleared by rst
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When undefined, redirect
// targets are silently word-aligned instead of faulting.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        PCsrc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        misalign_fault,
`endif
  input  logic [31:0] target_addr
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  // The timer holds the number of WAIT cycles already elapsed, so the
  // TIMEOUT-th WAIT cycle is the one where it reads TIMEOUT-1.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   instr_pc_q, instr_pc_d;
  logic [TW-1:0] timer_q, timer_d;

  // NOTE: every state register uses non-blocking assignment so all flops
  // update together from values computed before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      timer_q    <= timer_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    timer_d    = '0;

    unique case (state_q)
      ST_FETCH: state_d = ST_WAIT;

      ST_WAIT: begin
        // A response on the expiry cycle wins over the re-issue.
        if (imem_valid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = ST_DELIVER;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_FETCH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_DELIVER: begin
        if (!stall) begin
          state_d = ST_FETCH;
          if (PCsrc) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (target_addr[1:0] != 2'b00) begin
              state_d = ST_FAULT;
            end else begin
              pc_d = target_addr;
            end
`else
            pc_d = target_addr & 32'hFFFF_FFFC;
`endif
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

`ifdef FETCH_MISALIGN_CHECK_EN
      ST_FAULT: state_d = ST_FAULT;
`endif

      default: state_d = ST_FETCH;
    endcase
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = instr_pc_q + 32'd4;   // wraps modulo 2^32
  assign instr_valid = (state_q == ST_DELIVER);
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_fault = (state_q == ST_FAULT);
`endif

endmodule
